factorial_host_if: RTL and testbench
====================================

// Module: factorial_host_if
// PURPOSE
//  CPU-side memory-mapped front end for the factorial accelerator. It is the initiator
//  of the accelerator's go/done/error handshake.
//  - CPU writes operand and GO; block launches one job and waits for done.
//  - Result, status and a timeout watchdog are captured into CPU-readable registers.
//  - Sits between the processor's data-memory address decoder and the accelerator.
// PARAMETERS
//  N_WIDTH      4    operand width driven to the accelerator (zero-extended to 32 bits)
//  TIMEOUT      255  cycles in WAIT before abandoning the job with timeout status
//  CNT_WIDTH    8    watchdog counter width; must satisfy 2**CNT_WIDTH > TIMEOUT
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  we           in   1   CPU write strobe, qualified by sel
//  sel          in   1   address decoder hit for this block
//  addr         in   2   word select: 0=N, 1=GO, 2=STATUS, 3=RESULT
//  wd           in   32  CPU write data
//  rd           out  32  CPU read data, combinational from addr
//  fact_go      out  1   single-cycle start pulse to accelerator
//  fact_n       out  32  operand to accelerator, held stable for whole job
//  fact_done    in   1   accelerator completion
//  fact_err     in   1   accelerator error (operand out of range)
//  fact_result  in   32  accelerator result, valid when fact_done=1
// BEHAVIOUR
//  Reset (rst=0):
//   - State=IDLE; all registers, counter and outputs 0.
//   - Reset mid-job abandons the job immediately; no late capture after release.
//  Register map:
//   - N (RW): wd[N_WIDTH-1:0] stored; reads zero-extended.
//   - GO (RW bit0): write of 1 requests launch; reads 1 while busy.
//   - STATUS (RO): bit0 done, bit1 error, bit2 timeout, bit3 busy; bits[31:4]=0.
//   - RESULT (RO): last captured result.
//   - Writes to STATUS and RESULT are ignored.
//  FSM IDLE -> LAUNCH -> WAIT -> IDLE:
//   - IDLE:
//     - sel&we&addr=1&wd[0]=1 -> LAUNCH.
//     - Same cycle: latch N into fact_n; clear done, error and timeout.
//   - LAUNCH:
//     - fact_go=1 for exactly this one cycle; watchdog cleared.
//     - -> WAIT.
//   - WAIT:
//     - Watchdog increments each cycle.
//     - fact_done=1: RESULT<=fact_result, done<=1, error<=fact_err -> IDLE.
//     - Watchdog reaches TIMEOUT with no done: done<=1, timeout<=1, RESULT unchanged -> IDLE.
//     - fact_done and timeout in the same cycle: done wins, timeout stays 0.
//   - busy = (state != IDLE).
//  Latency: GO write at edge k; fact_go high in cycle k+1; done captured one cycle after fact_done.
//  Boundary rules:
//   - GO write while busy: ignored, no second launch.
//   - N write while busy: updates N register; fact_n unchanged until next launch.
//   - GO write of 0: no effect.
//   - fact_done seen in IDLE or LAUNCH: ignored.
//   - Capture is sticky: flags and RESULT hold until the next accepted GO.
// TESTING
//  - Reset: rst=0 mid-WAIT -> all outputs 0 next cycle; STATUS reads 0 after release.
//  - Normal job: write N=5, GO=1; model asserts done 20 cycles later with 120
//    -> fact_go one pulse, fact_n=5, RESULT=120, STATUS=0x1.
//  - Error: N=13, model returns fact_err=1 -> STATUS=0x3.
//  - Timeout: model never asserts done -> STATUS=0x5 exactly TIMEOUT cycles after WAIT entry; RESULT unchanged.
//  - Busy guard: GO rewritten and N=7 written during WAIT -> single fact_go; fact_n stays 5; STATUS bit3=1 until capture.
//  - Tie: fact_done asserted on the TIMEOUT cycle -> STATUS=0x1 and result captured.

Source files
------------

// File: rtl/factorial_host_if.sv
// CPU-side memory-mapped front end for the factorial accelerator.
// Launches one job per accepted GO write, then captures the result, the status flags and a watchdog timeout.
module factorial_host_if #(
    parameter int unsigned N_WIDTH   = 4,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        fact_go,
    output logic [31:0] fact_n,
    input  logic        fact_done,
    input  logic        fact_err,
    input  logic [31:0] fact_result
);

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                 state;
    logic [N_WIDTH-1:0]     n_reg;
    logic [31:0]            result;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   done;
    logic                   err;
    logic                   tmo;
    logic                   busy;
    logic                   n_wr;
    logic                   go_wr;
    logic                   unused_wd;

    assign busy      = (state != S_IDLE);
    assign n_wr      = sel && we && (addr == ADDR_N);
    assign go_wr     = sel && we && (addr == ADDR_GO);
    assign unused_wd = ^wd;

    // Job sequencer: the operand is frozen into fact_n at launch so later N writes cannot disturb a running job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            n_reg   <= '0;
            result  <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            tmo     <= 1'b0;
            fact_go <= 1'b0;
            fact_n  <= '0;
        end else begin
            fact_go <= 1'b0;
            if (n_wr) begin
                n_reg <= wd[N_WIDTH-1:0];
            end
            case (state)
                S_IDLE: begin
                    if (go_wr && wd[0]) begin
                        state   <= S_LAUNCH;
                        fact_go <= 1'b1;
                        fact_n  <= 32'(n_reg);
                        done    <= 1'b0;
                        err     <= 1'b0;
                        tmo     <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over the watchdog expiring in the same cycle.
                    if (fact_done) begin
                        result <= fact_result;
                        done   <= 1'b1;
                        err    <= fact_err;
                        state  <= S_IDLE;
                    end else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                        done  <= 1'b1;
                        tmo   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read mux, combinational from addr.
    always_comb begin
        rd = '0;
        case (addr)
            ADDR_N:      rd = 32'(n_reg);
            ADDR_GO:     rd = {31'b0, busy};
            ADDR_STATUS: rd = {28'b0, busy, tmo, err, done};
            ADDR_RESULT: rd = result;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_factorial_host_if.sv
// Directed bench for factorial_host_if: a CPU model drives register accesses and an inline accelerator model,
// while a scoreboard queue holds the expected STATUS/RESULT of each launched job.
module tb_factorial_host_if;

    localparam int unsigned TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        we;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fact_go;
    logic [31:0] fact_n;
    logic        fact_done;
    logic        fact_err;
    logic [31:0] fact_result;

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];
    int   pass_count = 0;
    int   total      = 0;
    int   go_count   = 0;
    int   go_base;
    logic [31:0] d;

    factorial_host_if #(.N_WIDTH(4), .TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .we(we), .sel(sel), .addr(addr), .wd(wd), .rd(rd),
        .fact_go(fact_go), .fact_n(fact_n), .fact_done(fact_done),
        .fact_err(fact_err), .fact_result(fact_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fact_go === 1'b1) go_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called at a negedge; the write is accepted on the next rising edge and the task returns at the following negedge.
    task automatic cpu_write(input logic [1:0] a, input logic [31:0] data);
        sel = 1'b1; we = 1'b1; addr = a; wd = data;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wd = '0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] data);
        addr = a;
        #1;
        data = rd;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        logic        found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cpu_read(2'd2, s);
            if (s[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic sb_compare(input string tag);
        exp_t        e;
        logic [31:0] s;
        logic [31:0] r;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            cpu_read(2'd2, s);
            cpu_read(2'd3, r);
            check({tag, "_status"}, s, e.status);
            check({tag, "_result"}, r, e.result);
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wd = '0;
        fact_done = 1'b0; fact_err = 1'b0; fact_result = '0;
        repeat (3) @(negedge clk);
        check("reset_go", 32'(fact_go), 32'd0);
        check("reset_n_out", fact_n, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        cpu_read(2'd2, d); check("reset_status", d, 32'd0);
        cpu_read(2'd3, d); check("reset_result", d, 32'd0);
        cpu_read(2'd0, d); check("reset_n_reg", d, 32'd0);

        // Normal job with busy guard: N=5, 5! = 120.
        cpu_write(2'd0, 32'hFFFF_FFF5);
        cpu_read(2'd0, d); check("n_zero_ext", d, 32'd5);
        go_base = go_count;
        cpu_write(2'd1, 32'd1);
        sb.push_back('{status: 32'h1, result: 32'd120});
        check("launch_go", 32'(fact_go), 32'd1);
        check("launch_n", fact_n, 32'd5);
        @(negedge clk);
        check("go_one_cycle", 32'(fact_go), 32'd0);
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd0, 32'd7);
        check("guard_fact_n", fact_n, 32'd5);
        cpu_read(2'd2, d); check("guard_busy", d, 32'h8);
        cpu_read(2'd1, d); check("guard_go_read", d, 32'd1);
        cpu_read(2'd0, d); check("guard_n_reg", d, 32'd7);
        repeat (15) @(negedge clk);
        fact_done = 1'b1; fact_result = 32'd120;
        @(negedge clk);
        fact_done = 1'b0; fact_result = '0;
        wait_done("normal_wait");
        sb_compare("normal");
        check("normal_go_count", 32'(go_count - go_base), 32'd1);

        // Writes to RO registers and GO=0 have no effect; stray done in IDLE is ignored.
        cpu_write(2'd3, 32'hDEAD_BEEF);
        cpu_write(2'd2, 32'hF);
        cpu_write(2'd1, 32'd0);
        fact_done = 1'b1; fact_err = 1'b1; fact_result = 32'd55;
        @(negedge clk);
        fact_done = 1'b0; fact_err = 1'b0; fact_result = '0;
        cpu_read(2'd3, d); check("ro_result", d, 32'd120);
        cpu_read(2'd2, d); check("ro_status", d, 32'h1);
        check("go0_go_count", 32'(go_count - go_base), 32'd1);

        // Timeout: no done; flags appear exactly TIMEOUT cycles after WAIT entry.
        cpu_write(2'd1, 32'd1);
        sb.push_back('{status: 32'h5, result: 32'd120});
        check("tmo_fact_n", fact_n, 32'd7);
        repeat (TIMEOUT) @(negedge clk);
        cpu_read(2'd2, d); check("tmo_not_yet", d, 32'h8);
        @(negedge clk);
        sb_compare("timeout");

        // Error: N=13, accelerator reports error.
        cpu_write(2'd0, 32'd13);
        cpu_write(2'd1, 32'd1);
        sb.push_back('{status: 32'h3, result: 32'd0});
        check("err_fact_n", fact_n, 32'd13);
        repeat (3) @(negedge clk);
        fact_done = 1'b1; fact_err = 1'b1; fact_result = 32'd0;
        @(negedge clk);
        fact_done = 1'b0; fact_err = 1'b0;
        wait_done("err_wait");
        sb_compare("error");

        // Tie: done on the final watchdog cycle wins over timeout.
        cpu_write(2'd0, 32'd4);
        cpu_write(2'd1, 32'd1);
        sb.push_back('{status: 32'h1, result: 32'd24});
        repeat (TIMEOUT) @(negedge clk);
        cpu_read(2'd2, d); check("tie_still_busy", d, 32'h8);
        fact_done = 1'b1; fact_result = 32'd24;
        @(negedge clk);
        fact_done = 1'b0; fact_result = '0;
        sb_compare("tie");

        // Reset mid-WAIT abandons the job; a late done after release is not captured.
        cpu_write(2'd1, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_go", 32'(fact_go), 32'd0);
        check("rst_mid_n", fact_n, 32'd0);
        cpu_read(2'd2, d); check("rst_mid_status", d, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        fact_done = 1'b1; fact_result = 32'd777;
        @(negedge clk);
        fact_done = 1'b0; fact_result = '0;
        @(negedge clk);
        cpu_read(2'd2, d); check("post_rst_status", d, 32'd0);
        cpu_read(2'd3, d); check("post_rst_result", d, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

endmodule
